// File: rtl/int_pkg.sv
// Shared types and defaults for the interrupt scheduler.
package int_pkg;

  localparam int unsigned NUM_SRC_MAX = 8;
  localparam int unsigned ID_W        = 3;
  localparam int unsigned ADDR_W      = 32;

  localparam logic [ADDR_W-1:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam logic [ADDR_W-1:0] VEC_STRIDE_DEF = 32'h0000_0010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module int_prio_enc
  import int_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]    req,
  output logic            any,
  output logic [ID_W-1:0] id
);

  always_comb begin
    any = |req;
    id  = '0;
    // Scan downward so the lowest index is the last, winning assignment.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_sched_ctrl.sv
// Interrupt scheduler: captures peripheral done edges, grants one source at a time
// by fixed priority and holds off further requests until the handler returns.
module int_sched_ctrl
  import int_pkg::*;
#(
  parameter int unsigned        NUM_SRC    = 4,
  parameter logic [ADDR_W-1:0]  VEC_BASE   = VEC_BASE_DEF,
  parameter logic [ADDR_W-1:0]  VEC_STRIDE = VEC_STRIDE_DEF,
  parameter logic [NUM_SRC-1:0] MASK_RST   = {NUM_SRC{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] done,
  input  logic               int_ack,
  input  logic               int_done,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wd,
  input  logic               ovf_clr,
  output logic               interrupt,
  output logic [ADDR_W-1:0]  int_addr,
  output logic [ID_W-1:0]    active_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] overrun
);

  state_e              state_q, state_d;
  logic                interrupt_q, interrupt_d;
  logic [ADDR_W-1:0]   int_addr_q, int_addr_d;
  logic [ID_W-1:0]     active_id_q, active_id_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  mask_q, mask_d;
  logic [NUM_SRC-1:0]  overrun_q, overrun_d;
  logic [NUM_SRC-1:0]  done_prev_q, done_prev_d;

  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  ack_clr;
  logic                enc_any;
  logic [ID_W-1:0]     enc_id;

  int_prio_enc #(
    .N (NUM_SRC)
  ) u_prio_enc (
    .req (pending_q & mask_q),
    .any (enc_any),
    .id  (enc_id)
  );

  // Event capture, mask and overrun bookkeeping.
  always_comb begin
    rise        = done & ~done_prev_q;
    done_prev_d = done;
    ack_clr     = '0;
    if (state_q == REQ && int_ack) ack_clr = NUM_SRC'(1) << active_id_q;
    // A new rising edge outranks the acknowledge clear of the same cycle.
    pending_d   = (pending_q & ~ack_clr) | rise;
    overrun_d   = (ovf_clr ? '0 : overrun_q) | (rise & pending_q);
    mask_d      = mask_we ? mask_wd : mask_q;
  end

  // Request / service sequencing.
  always_comb begin
    state_d     = state_q;
    interrupt_d = interrupt_q;
    int_addr_d  = int_addr_q;
    active_id_d = active_id_q;
    unique case (state_q)
      IDLE: begin
        if (enc_any) begin
          active_id_d = enc_id;
          int_addr_d  = VEC_BASE + ADDR_W'(enc_id) * VEC_STRIDE;
          interrupt_d = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          interrupt_d = 1'b0;
          state_d     = SVC;
        end
      end
      SVC: begin
        interrupt_d = 1'b0;
        if (int_done) state_d = IDLE;
      end
      default: begin
        interrupt_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      interrupt_q <= 1'b0;
      int_addr_q  <= '0;
      active_id_q <= '0;
      pending_q   <= '0;
      mask_q      <= MASK_RST;
      overrun_q   <= '0;
      done_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      interrupt_q <= interrupt_d;
      int_addr_q  <= int_addr_d;
      active_id_q <= active_id_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      overrun_q   <= overrun_d;
      done_prev_q <= done_prev_d;
    end
  end

  assign interrupt = interrupt_q;
  assign int_addr  = int_addr_q;
  assign active_id = active_id_q;
  assign pending   = pending_q;
  assign mask      = mask_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_int_sched_ctrl.sv
// Scoreboard bench for int_sched_ctrl: expected grants are queued by the stimulus
// and checked by a monitor on every rising edge of interrupt.
module tb_int_sched_ctrl;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  done;
  logic          int_ack;
  logic          int_done;
  logic          mask_we;
  logic [N-1:0]  mask_wd;
  logic          ovf_clr;
  logic          interrupt;
  logic [31:0]   int_addr;
  logic [2:0]    active_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  mask;
  logic [N-1:0]  overrun;

  int tests  = 0;
  int errors = 0;

  logic [34:0] exp_q[$];
  logic        prev_int = 1'b0;

  int_sched_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .int_ack   (int_ack),
    .int_done  (int_done),
    .mask_we   (mask_we),
    .mask_wd   (mask_wd),
    .ovf_clr   (ovf_clr),
    .interrupt (interrupt),
    .int_addr  (int_addr),
    .active_id (active_id),
    .pending   (pending),
    .mask      (mask),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Monitor: every new request must match the oldest queued grant.
  always @(negedge clk) begin
    if (interrupt && !prev_int) begin
      logic [34:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: got addr=%h id=%0d, required no request", int_addr, active_id);
      end else begin
        e = exp_q.pop_front();
        if ({int_addr, active_id} !== e) begin
          errors++;
          $display("FAIL grant: got addr=%h id=%0d, required addr=%h id=%0d",
                   int_addr, active_id, e[34:3], e[2:0]);
        end
      end
    end
    prev_int <= interrupt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_grant(input logic [31:0] addr, input logic [2:0] id);
    exp_q.push_back({addr, id});
  endtask

  task automatic wait_int();
    int n = 0;
    while (!interrupt && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (!interrupt) begin
      errors++;
      $display("FAIL wait_int: got interrupt=0 after 20 cycles, required 1");
    end
  endtask

  task automatic pulse(input logic [N-1:0] v);
    done = v;
    tick();
    done = '0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic finish_handler();
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; done = '0; int_ack = 1'b0; int_done = 1'b0;
    mask_we = 1'b0; mask_wd = '0; ovf_clr = 1'b0;
    tick(); tick();
    check("rst_interrupt", 32'(interrupt), 32'h0);
    check("rst_int_addr", int_addr, 32'h0);
    check("rst_mask", 32'(mask), 32'hf);
    reset = 1'b0;
    tick();

    // 1: single event, two-edge latency
    expect_grant(32'h120, 3'd2);
    pulse(4'b0100);
    check("t1_pending", 32'(pending), 32'h4);
    check("t1_int_not_yet", 32'(interrupt), 32'h0);
    tick();
    check("t1_int_next_edge", 32'(interrupt), 32'h1);
    ack();
    check("t1_int_after_ack", 32'(interrupt), 32'h0);
    finish_handler();

    // 2: two simultaneous events, priority order
    expect_grant(32'h110, 3'd1);
    expect_grant(32'h130, 3'd3);
    pulse(4'b1010);
    wait_int(); ack(); finish_handler();
    wait_int(); ack(); finish_handler();
    check("t2_pending_zero", 32'(pending), 32'h0);

    // 3: masked source stays pending until unmasked
    mask_we = 1'b1; mask_wd = 4'b1110; tick(); mask_we = 1'b0;
    pulse(4'b0001);
    tick(); tick();
    check("t3_pending", 32'(pending), 32'h1);
    check("t3_no_int", 32'(interrupt), 32'h0);
    expect_grant(32'h100, 3'd0);
    mask_we = 1'b1; mask_wd = 4'b1111; tick(); mask_we = 1'b0;
    wait_int(); ack(); finish_handler();

    // 4: grant is stable in REQ against new events and mask writes
    expect_grant(32'h120, 3'd2);
    pulse(4'b0100);
    wait_int();
    done = 4'b0001; mask_we = 1'b1; mask_wd = 4'b0000;
    tick();
    done = '0; mask_we = 1'b0;
    tick();
    check("t4_hold_int", 32'(interrupt), 32'h1);
    check("t4_hold_id", 32'(active_id), 32'h2);
    check("t4_hold_addr", int_addr, 32'h120);
    ack(); finish_handler();
    tick(); tick();
    check("t4_masked_no_int", 32'(interrupt), 32'h0);
    check("t4_pending", 32'(pending), 32'h1);
    expect_grant(32'h100, 3'd0);
    mask_we = 1'b1; mask_wd = 4'b1111; tick(); mask_we = 1'b0;
    wait_int(); ack(); finish_handler();

    // 5: re-rise on the ack cycle keeps the event and flags overrun
    expect_grant(32'h110, 3'd1);
    pulse(4'b0010);
    wait_int();
    done = 4'b0010; int_ack = 1'b1;
    tick();
    done = '0; int_ack = 1'b0;
    check("t5_pending", 32'(pending), 32'h2);
    check("t5_overrun", 32'(overrun), 32'h2);
    check("t5_int_low", 32'(interrupt), 32'h0);
    expect_grant(32'h110, 3'd1);
    finish_handler();
    wait_int(); ack(); finish_handler();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t5_ovf_clr", 32'(overrun), 32'h0);

    // 6: reset during service; held done counts once after release
    expect_grant(32'h110, 3'd1);
    pulse(4'b0110);
    wait_int(); ack();
    pulse(4'b0010);
    check("t6_svc_pending", 32'(pending), 32'h6);
    done = 4'b0110; reset = 1'b1;
    tick();
    check("t6_rst_pending", 32'(pending), 32'h0);
    check("t6_rst_id", 32'(active_id), 32'h0);
    check("t6_rst_addr", int_addr, 32'h0);
    check("t6_rst_overrun", 32'(overrun), 32'h0);
    tick();
    expect_grant(32'h110, 3'd1);
    reset = 1'b0;
    tick();
    check("t6_capture", 32'(pending), 32'h6);
    wait_int();
    tick(); tick();
    check("t6_single_event", 32'(overrun), 32'h0);
    ack();
    check("t6_after_ack", 32'(pending), 32'h4);
    done = '0;
    tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
